dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle RISC-V CPU. It receives the CPU data-port transactions and returns read data combinationally in the same cycle. Writes commit on the rising clock edge with byte/half/word lane handling. Besides the RAM, it decodes a small peripheral window holding a 64-bit free-running timer, a compare register, sticky status flags and an interrupt output.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 to DEPTH_WORDS*4-1.
- PERIPH_BASE, 32'h0000_1000, base of the 32-byte peripheral window; must be 32-byte aligned and above the RAM.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  write strobe for the current cycle.
- Mem_WrAddr  in  32  byte address for both read and write.
- Mem_WrData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- StoreSize  in  2  2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 treated as word.
- ReadData  out  32  combinational read data, full aligned word.
- irq  out  1  timer interrupt request.

## Operation
- Decode:
  - RAM hit when Mem_WrAddr < DEPTH_WORDS*4.
  - Peripheral hit when Mem_WrAddr[31:5] == PERIPH_BASE[31:5].
  - Anything else is unmapped: reads return 0 and writes are dropped.
- RAM reads return the word at Mem_WrAddr[..:2]. The CPU extracts sub-words, so addr[1:0] is ignored on reads.
- RAM writes use lane enables from StoreSize and addr[1:0]:
  - Byte: data goes to lane addr[1:0], i.e. Mem_WrData[7:0] shifted by 8*addr[1:0].
  - Half: data goes to lanes {addr[1],0}.
  - Word: all four lanes.
  - Untouched lanes keep their value.
- Misaligned store (half with addr[0]=1, or word with addr[1:0]≠0, to RAM or peripherals): the write is dropped and STATUS.MISALIGN is set.
- Peripheral registers, at offset = addr[4:0]. Sub-word stores to peripherals behave as word writes of the zero-extended data.
  - 0x00 MTIME_LO, RW.
  - 0x04 MTIME_HI, RW.
  - 0x08 MTIMECMP, RW, compared against MTIME_LO.
  - 0x0C STATUS. Bit0 MATCH and bit1 MISALIGN are sticky; write 1 to clear.
  - 0x10 CTRL, RW. Bit0 TEN (timer enable), bit1 IEN (interrupt enable).
  - Other offsets read 0 and writes are ignored.
- Timer:
  - When TEN=1, the 64-bit {MTIME_HI, MTIME_LO} increments by 1 each cycle and wraps from 2^64-1 to 0.
  - A CPU write to MTIME_LO or MTIME_HI that cycle loads the written half instead of incrementing it. The other half still follows the increment, including carry.
- Match: when TEN=1 and the current MTIME_LO == MTIMECMP, MATCH is set at the next edge.
- Flag priority: set beats W1C in the same cycle, for both MATCH and MISALIGN.
- irq = STATUS.MATCH & CTRL.IEN. It is driven combinationally from registers.
- Reset:
  - MTIME, MTIMECMP, STATUS and CTRL clear to 0, so irq=0.
  - RAM contents are not reset.
  - ReadData reflects the reset register values immediately.

## Timing
- Read latency 0: ReadData is a function of the address and current state in the same cycle.
- Write latency 1 edge: the new value is visible on ReadData in the cycle after MemWrite.
- Read-during-write to the same address returns the old value.
- MATCH is set one edge after the compare cycle; irq rises in the same cycle as MATCH.
- Reset asserted mid-operation clears registers immediately (asynchronously). The first increment occurs on the first edge after reset deasserts with TEN=1.

## Test plan
- Word write 0xDEADBEEF to 0x10, then sb 0xAA to 0x11 and sh 0x1234 to 0x12 -> read 0x10 = 0x1234AAEF.
- sw to 0x06 -> RAM unchanged, STATUS=0x2; write 0x2 to 0x100C -> STATUS=0x0.
- Write CTRL=0x3 and MTIMECMP=5 with MTIME=0 -> MATCH and irq=1 at the edge after MTIME_LO reads 5; W1C MATCH -> irq=0.
- Set MTIME_LO=0xFFFFFFFF, MTIME_HI=0, TEN=1 -> next cycle MTIME_LO=0, MTIME_HI=1. Also load MTIME to 2^64-1 -> wraps to 0.
- Issue W1C to MATCH in the same cycle a new match occurs -> MATCH remains 1.
- Read 0x2000 (unmapped) -> 0; write there -> no state change; assert reset mid-count -> all registers 0 and irq=0 asynchronously, RAM contents retained.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RISC-V CPU: combinational-read RAM with
// byte/half/word stores, plus a 32-byte peripheral window with a 64-bit timer and irq.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] PERIPH_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [1:0]  StoreSize,
    output logic [31:0] ReadData,
    output logic        irq
);

    localparam int          DATA_W    = 32;
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [4:0] OFF_MTIME_LO = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP = 5'h08;
    localparam logic [4:0] OFF_STATUS   = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        if (size == SZ_BYTE)
            return 1'b0;
        else if (size == SZ_HALF)
            return a[0];
        else
            return a != 2'b00;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the right-aligned data puts it on every lane; enables pick the lanes.
    function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size,
                                                    input logic [DATA_W-1:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] periph_data(input logic [1:0] size,
                                                      input logic [DATA_W-1:0] d);
        case (size)
            SZ_BYTE: return {24'd0, d[7:0]};
            SZ_HALF: return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              ram_hit;
    logic              periph_hit;
    logic              misaligned;
    logic              ram_we;
    logic              periph_we;
    logic              misalign_evt;
    logic [AW-1:0]     ram_idx;
    logic [4:0]        off;
    logic [3:0]        lane_en;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] pwdata;

    logic [31:0]       mtime_lo;
    logic [31:0]       mtime_hi;
    logic [31:0]       mtimecmp;
    logic              st_match;
    logic              st_misalign;
    logic              ctrl_ten;
    logic              ctrl_ien;

    logic [63:0]       mtime_inc;
    logic              wr_lo;
    logic              wr_hi;
    logic              wr_cmp;
    logic              wr_status;
    logic              wr_ctrl;
    logic              match_set;

    assign ram_hit      = Mem_WrAddr < RAM_BYTES;
    assign periph_hit   = Mem_WrAddr[31:5] == PERIPH_BASE[31:5];
    assign misaligned   = is_misaligned(StoreSize, Mem_WrAddr[1:0]);
    assign ram_we       = MemWrite & ram_hit & ~misaligned;
    assign periph_we    = MemWrite & periph_hit & ~misaligned;
    assign misalign_evt = MemWrite & (ram_hit | periph_hit) & misaligned;
    assign ram_idx      = Mem_WrAddr[AW+1:2];
    assign off          = Mem_WrAddr[4:0];
    assign lane_en      = lane_enables(StoreSize, Mem_WrAddr[1:0]);
    assign lane_wdata   = lane_data(StoreSize, Mem_WrData);
    assign pwdata       = periph_data(StoreSize, Mem_WrData);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l])
                    mem[ram_idx][8*l +: 8] <= lane_wdata[8*l +: 8];
            end
        end
    end

    assign mtime_inc = {mtime_hi, mtime_lo} + 64'd1;
    assign wr_lo     = periph_we && (off == OFF_MTIME_LO);
    assign wr_hi     = periph_we && (off == OFF_MTIME_HI);
    assign wr_cmp    = periph_we && (off == OFF_MTIMECMP);
    assign wr_status = periph_we && (off == OFF_STATUS);
    assign wr_ctrl   = periph_we && (off == OFF_CTRL);
    assign match_set = ctrl_ten && (mtime_lo == mtimecmp);

    // A written half is loaded; the other half still takes the 64-bit increment (with carry).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_lo    <= '0;
            mtime_hi    <= '0;
            mtimecmp    <= '0;
            st_match    <= 1'b0;
            st_misalign <= 1'b0;
            ctrl_ten    <= 1'b0;
            ctrl_ien    <= 1'b0;
        end else begin
            if (wr_lo)
                mtime_lo <= pwdata;
            else if (ctrl_ten)
                mtime_lo <= mtime_inc[31:0];

            if (wr_hi)
                mtime_hi <= pwdata;
            else if (ctrl_ten)
                mtime_hi <= mtime_inc[63:32];

            if (wr_cmp)
                mtimecmp <= pwdata;

            st_match    <= match_set    | (st_match    & ~(wr_status & pwdata[0]));
            st_misalign <= misalign_evt | (st_misalign & ~(wr_status & pwdata[1]));

            if (wr_ctrl) begin
                ctrl_ten <= pwdata[0];
                ctrl_ien <= pwdata[1];
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = mem[ram_idx];
        end else if (periph_hit) begin
            case (off)
                OFF_MTIME_LO: ReadData = mtime_lo;
                OFF_MTIME_HI: ReadData = mtime_hi;
                OFF_MTIMECMP: ReadData = mtimecmp;
                OFF_STATUS:   ReadData = {30'd0, st_misalign, st_match};
                OFF_CTRL:     ReadData = {30'd0, ctrl_ien, ctrl_ten};
                default:      ReadData = '0;
            endcase
        end
    end

    assign irq = st_match & ctrl_ien;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, misalignment, unmapped space, timer,
// match/irq flag priority and asynchronous reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = '0;
    logic [31:0] Mem_WrData = '0;
    logic [1:0]  StoreSize = 2'b00;
    logic [31:0] ReadData;
    logic        irq;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] P_LO   = 32'h0000_1000;
    localparam logic [31:0] P_HI   = 32'h0000_1004;
    localparam logic [31:0] P_CMP  = 32'h0000_1008;
    localparam logic [31:0] P_STAT = 32'h0000_100C;
    localparam logic [31:0] P_CTRL = 32'h0000_1010;

    dmem_responder #(.DEPTH_WORDS(64), .PERIPH_BASE(32'h0000_1000)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData), .StoreSize(StoreSize), .ReadData(ReadData), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Mem_WrAddr = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        Mem_WrAddr = a;
        Mem_WrData = d;
        StoreSize  = sz;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk_irq("rst_irq", 1'b0);
        rd("rst_mtime_lo", P_LO, 32'h0);
        rd("rst_status", P_STAT, 32'h0);
        rd("rst_ctrl", P_CTRL, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // RAM lane handling
        wr(32'h10, 32'hDEAD_BEEF, 2'b10);
        rd("sw_word", 32'h10, 32'hDEAD_BEEF);
        wr(32'h11, 32'h0000_00AA, 2'b00);
        rd("sb_lane1", 32'h10, 32'hDEAD_AAEF);
        wr(32'h12, 32'h0000_1234, 2'b01);
        rd("sh_upper_addr13", 32'h13, 32'h1234_AAEF);

        // read-during-write returns the old word
        Mem_WrAddr = 32'h10; Mem_WrData = 32'h55; StoreSize = 2'b10; MemWrite = 1'b1;
        #1;
        check("rdw_old", ReadData, 32'h1234_AAEF);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        rd("rdw_new", 32'h10, 32'h0000_0055);

        // misaligned stores
        wr(32'h04, 32'h1111_1111, 2'b10);
        wr(32'h06, 32'hFFFF_FFFF, 2'b10);
        rd("misal_sw_ram", 32'h04, 32'h1111_1111);
        rd("misal_sw_status", P_STAT, 32'h2);
        wr(P_STAT, 32'h2, 2'b10);
        rd("w1c_misal", P_STAT, 32'h0);
        wr(32'h05, 32'h0000_FFFF, 2'b01);
        rd("misal_sh_ram", 32'h04, 32'h1111_1111);
        rd("misal_sh_status", P_STAT, 32'h2);
        wr(P_STAT, 32'h2, 2'b10);

        // unmapped space
        rd("unmapped_rd", 32'h2000, 32'h0);
        wr(32'h2000, 32'hFFFF_FFFF, 2'b10);
        rd("unmapped_rd2", 32'h2000, 32'h0);
        rd("unmapped_status", P_STAT, 32'h0);
        rd("unmapped_ram", 32'h04, 32'h1111_1111);

        // timer match and irq
        wr(P_CMP, 32'd5, 2'b10);
        wr(P_CTRL, 32'h3, 2'b10);
        rd("ctrl_rd", P_CTRL, 32'h3);
        rd("mtime_start", P_LO, 32'd0);
        repeat (5) tick();
        rd("mtime_at5", P_LO, 32'd5);
        chk_irq("irq_before_match", 1'b0);
        tick();
        chk_irq("irq_match", 1'b1);
        rd("status_match", P_STAT, 32'h1);
        wr(P_STAT, 32'h1, 2'b10);
        chk_irq("irq_w1c", 1'b0);
        rd("status_w1c", P_STAT, 32'h0);

        // set beats W1C (lo=7 now)
        wr(P_CMP, 32'd10, 2'b10);
        tick();
        tick();
        rd("mtime_at10", P_LO, 32'd10);
        wr(P_STAT, 32'h1, 2'b10);
        rd("set_beats_w1c", P_STAT, 32'h1);
        chk_irq("irq_set_beats_w1c", 1'b1);
        wr(P_STAT, 32'h1, 2'b10);
        rd("status_cleared", P_STAT, 32'h0);

        // carry from low to high
        wr(P_CTRL, 32'h0, 2'b10);
        wr(P_LO, 32'hFFFF_FFFF, 2'b10);
        wr(P_HI, 32'h0, 2'b10);
        wr(P_CTRL, 32'h1, 2'b10);
        rd("carry_lo_pre", P_LO, 32'hFFFF_FFFF);
        tick();
        rd("carry_lo", P_LO, 32'h0);
        rd("carry_hi", P_HI, 32'h1);

        // 64-bit wrap
        wr(P_CTRL, 32'h0, 2'b10);
        wr(P_LO, 32'hFFFF_FFFF, 2'b10);
        wr(P_HI, 32'hFFFF_FFFF, 2'b10);
        wr(P_CTRL, 32'h1, 2'b10);
        rd("wrap_hi_pre", P_HI, 32'hFFFF_FFFF);
        tick();
        rd("wrap_lo", P_LO, 32'h0);
        rd("wrap_hi", P_HI, 32'h0);

        // loading one half while the other takes the carry
        wr(P_CTRL, 32'h0, 2'b10);
        wr(P_LO, 32'hFFFF_FFFE, 2'b10);
        wr(P_CTRL, 32'h1, 2'b10);
        wr(P_HI, 32'h7, 2'b10);
        rd("load_hi_lo_incs", P_LO, 32'hFFFF_FFFF);
        wr(P_LO, 32'h5, 2'b10);
        rd("load_lo", P_LO, 32'h5);
        rd("load_lo_hi_carry", P_HI, 32'h8);

        // asynchronous reset mid-count
        wr(P_CTRL, 32'h0, 2'b10);
        wr(P_LO, 32'd20, 2'b10);
        wr(P_CMP, 32'd20, 2'b10);
        wr(P_CTRL, 32'h3, 2'b10);
        tick();
        chk_irq("irq_pre_reset", 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_irq("reset_irq", 1'b0);
        rd("reset_lo", P_LO, 32'h0);
        rd("reset_hi", P_HI, 32'h0);
        rd("reset_cmp", P_CMP, 32'h0);
        rd("reset_status", P_STAT, 32'h0);
        rd("reset_ctrl", P_CTRL, 32'h0);
        rd("reset_ram10", 32'h10, 32'h0000_0055);
        rd("reset_ram04", 32'h04, 32'h1111_1111);
        @(negedge clk);
        reset = 1'b0;
        tick();
        rd("post_reset_lo", P_LO, 32'h0);
        wr(P_CTRL, 32'h1, 2'b10);
        rd("ten_edge_lo", P_LO, 32'h0);
        tick();
        rd("first_inc", P_LO, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
